uart_rx_sampler: RTL
====================

# uart_rx_sampler

16x-oversampling UART receiver. It converts the asynchronous serial line into bytes on a valid/ready handshake. It is the stage directly upstream of the 8-entry io_generic_fifo in the off-chip UART loopback peripheral: rx_data_o/rx_valid_o/rx_ready_i connect straight to the FIFO write side. It adds majority-vote sampling, start-bit glitch rejection, framing/overrun reporting and optional parity checking.

## Interface
- DIVISOR, 4: clk cycles per oversample tick; baud = f_clk / (DIVISOR*16); legal range 1..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk externally.
- rx_i  in  1  raw serial line, idle high, asynchronous to clk.
- cfg_en_i  in  1  receiver enable; 0 forces IDLE.
- rx_data_o  out  8  received byte, stable while rx_valid_o=1.
- rx_valid_o  out  1  byte available.
- rx_ready_i  in  1  consumer accepts byte when rx_valid_o & rx_ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  out  1  one-cycle pulse: completed byte dropped, holding register full.
- busy_o  out  1  1 whenever state != IDLE.
- parity_err_o  out  1  one-cycle pulse: parity mismatch (present only with UART_RX_PARITY_EN).

## Operation
- rx_i passes through a 2-flop synchronizer (flops reset to 1), then one edge-detect flop.
- Tick generator: counter 0..DIVISOR-1, tick when count = DIVISOR-1; cleared to 0 on entry to START.
- Sample counter 0..15 per bit, advances on tick. Samples are taken at 7, 8 and 9; majority vote at sample 9. Bit ends at sample 15.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE -> START: synced falling edge (1->0) while cfg_en_i=1.
- START: vote=1 at sample 9 -> IDLE (glitch rejected, no flags). Otherwise at sample 15 -> DATA, bit index 0.
- DATA: vote shifted in LSB first. After bit 7, sample 15 -> PARITY if compiled in, else STOP.
- STOP: decided at sample 9, then return to IDLE in the same cycle, which leaves half a bit of margin for a back-to-back start.
  - vote=1: deliver the byte.
  - vote=0: frame_err_o pulse, byte discarded.
- Deliver: if holding register empty, or rx_valid_o & rx_ready_i in the same cycle, load rx_data_o and set rx_valid_o. Otherwise pulse overrun_o, drop the new byte and keep the held byte.
- rx_valid_o clears on handshake unless a new byte is loaded in that same cycle.
- cfg_en_i=0 mid-frame: next cycle state=IDLE, partial byte discarded, no flags; holding register and handshake unaffected.

## Timing
- Reset values: rx_data_o=0x00, rx_valid_o=0, frame_err_o=0, overrun_o=0, parity_err_o=0, busy_o=0, state=IDLE, counters=0.
- Input latency: 2 cycles sync + 1 cycle edge detect before START is entered.
- rx_valid_o rises 1 cycle after the stop-bit sample-9 tick; flag pulses are aligned with that same cycle.
- Frame length: 10 bits (11 with parity) at 16*DIVISOR cycles/bit; the decision point sits 9.5 samples into the stop bit.
- Reset mid-frame: immediate return to reset values; no output.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state inserted after DATA; even parity, voted like data bits.
  - A mismatch pulses parity_err_o at the delivery cycle; the byte is still delivered (or overruns) normally.
  - parity_err_o port exists.
- Undefined: 8N1 only; no PARITY state, no parity_err_o port.

## Structure
- Package uart_pkg:
  - state enum (RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP);
  - OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, SAMPLE_LAST=15;
  - DATA_BITS=8.
- One sub-module, uart_baud_tick: DIVISOR counter with a sync clear input and a tick output; reusable by the matching transmitter.
- Synchronizer, vote, FSM and holding register stay in the top module.

## Test plan
- DIVISOR=4 (64 cycles/bit), send 0xA5 8N1, rx_ready_i=1 -> single rx_valid_o pulse with rx_data_o=0xA5; frame_err_o and overrun_o never assert.
- rx_i low for 16 cycles then high -> busy_o asserts and then returns to 0; no rx_valid_o, no flags.
- Send 0x3C with stop bit forced 0 -> frame_err_o one-cycle pulse, rx_valid_o stays 0; a following 0x55 with a valid stop bit is received correctly.
- rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o=0x11 held valid, overrun_o pulses at the end of the second frame. Raise rx_ready_i -> handshake completes, rx_valid_o drops.
- With UART_RX_PARITY_EN, send 0x03 with parity bit 1 -> parity_err_o pulse and rx_data_o=0x03 valid; with parity bit 0 -> no pulse.
- Assert rst (0) during DATA bit 4 of 0xFF, release, then send 0x81 -> no output for the aborted frame, then rx_data_o=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types, sampling constants and helpers for the UART receive path.
//   rx_state_e  : receiver FSM states
//   SAMPLE_*    : oversample indices used for the 3-sample majority vote
//   maj3()      : majority of three samples
//   even_par()  : even-parity bit of a data byte
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  SAMPLE_LO   = 4'd7;
  localparam logic [3:0]  SAMPLE_MID  = 4'd8;
  localparam logic [3:0]  SAMPLE_HI   = 4'd9;
  localparam logic [3:0]  SAMPLE_LAST = 4'd15;
  localparam int unsigned DATA_BITS   = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Divides clk down to the 16x oversample tick. Counts 0..DIVISOR-1 and pulses
// o_tick when the count reaches DIVISOR-1. i_clr synchronously restarts the
// count at 0 (and suppresses the tick) so a frame starts phase-aligned.
//   clk, rst (async, active-low), i_clr, o_tick
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [15:0] CNT_LAST = 16'(DIVISOR - 1);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt == CNT_LAST) && !i_clr;

  // divider counter, wraps at DIVISOR-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 16'd0;
    end else if (i_clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// 16x oversampling UART receiver with majority vote (samples 7/8/9), start-bit
// glitch rejection, framing/overrun pulses and a valid/ready holding register.
// Optional even parity is compiled in with the macro UART_RX_PARITY_EN.
//   clk, rst (async, active-low)
//   rx_i          raw serial line (idle high)
//   cfg_en_i      receiver enable; 0 returns the FSM to IDLE
//   rx_data_o / rx_valid_o / rx_ready_i   byte handshake
//   frame_err_o, overrun_o, parity_err_o  one-cycle event pulses
//   busy_o        FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       cfg_en_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  rx_state_e   r_state;
  logic        r_sync1, r_sync2, r_rx_prev;
  logic [3:0]  r_samp;
  logic [2:0]  r_bit_idx;
  logic        r_s_lo, r_s_mid;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
  logic        r_parity_err;
`endif

  logic w_tick;
  logic w_fall;
  logic w_vote;
  logic w_tick_clr;

  // Synchronizer and edge-detect flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_fall     = r_rx_prev & ~r_sync2;
  // Third vote sample is the live synced level at the sample-9 tick.
  assign w_vote     = maj3(r_s_lo, r_s_mid, r_sync2);
  // Holding the divider clear in IDLE guarantees count 0 on entry to START.
  assign w_tick_clr = (r_state == RX_IDLE) || !cfg_en_i;

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  // Receiver FSM, sampling, holding register and event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RX_IDLE;
      r_samp      <= 4'd0;
      r_bit_idx   <= 3'd0;
      r_s_lo      <= 1'b1;
      r_s_mid     <= 1'b1;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Handshake drains the holding register; a same-cycle load below overrides.
      if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end

      if (!cfg_en_i) begin
        r_state <= RX_IDLE;
        r_samp  <= 4'd0;
      end else begin
        case (r_state)
          RX_IDLE: begin
            r_samp    <= 4'd0;
            r_bit_idx <= 3'd0;
            if (w_fall) begin
              r_state <= RX_START;
            end
          end
          default: begin
            if (w_tick) begin
              r_samp <= r_samp + 4'd1;
              if (r_samp == SAMPLE_LO)  r_s_lo  <= r_sync2;
              if (r_samp == SAMPLE_MID) r_s_mid <= r_sync2;
              case (r_state)
                RX_START: begin
                  if ((r_samp == SAMPLE_HI) && w_vote) begin
                    r_state <= RX_IDLE;
                  end else if (r_samp == SAMPLE_LAST) begin
                    r_state   <= RX_DATA;
                    r_bit_idx <= 3'd0;
                  end
                end
                RX_DATA: begin
                  if (r_samp == SAMPLE_HI) begin
                    r_shift <= {w_vote, r_shift[7:1]};
                  end else if (r_samp == SAMPLE_LAST) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                      r_state <= RX_PARITY;
`else
                      r_state <= RX_STOP;
`endif
                    end else begin
                      r_bit_idx <= r_bit_idx + 3'd1;
                    end
                  end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                  if (r_samp == SAMPLE_HI) begin
                    r_par_bit <= w_vote;
                  end else if (r_samp == SAMPLE_LAST) begin
                    r_state <= RX_STOP;
                  end
                end
`endif
                RX_STOP: begin
                  // Decide at sample 9 and leave immediately: half a bit of slack for the next start.
                  if (r_samp == SAMPLE_HI) begin
                    r_state <= RX_IDLE;
                    if (w_vote) begin
`ifdef UART_RX_PARITY_EN
                      r_parity_err <= even_par(r_shift) ^ r_par_bit;
`endif
                      if (!r_valid || rx_ready_i) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                      end else begin
                        r_overrun <= 1'b1;
                      end
                    end else begin
                      r_frame_err <= 1'b1;
                    end
                  end
                end
                default: begin
                  r_state <= RX_IDLE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = r_parity_err;
`endif
  assign busy_o      = (r_state != RX_IDLE);

endmodule
